dot_accumulator: RTL
====================

// Module: dot_accumulator
// PURPOSE
//  Sits directly downstream of the summation tree: consumes its per-cycle sum_out and
//  accumulates successive partial sums into one dot-product result per vector.
//  Tracks tree latency with an internal valid/last delay line, so the issue side drives
//  valid/last in the same cycle it launches PE operands.
//  Presents each finished result on a valid/ready output port with overflow detection.
// PARAMETERS
//  DATA_LEN  32  width of sum_in (two's complement, signed)
//  ACC_LEN   40  accumulator/result width; must be >= DATA_LEN
//  TREE_LAT  2   cycles from operand issue to matching sum_in (adder levels in tree), >=1
// PORTS
//  clk        in   1         clock, rising edge
//  rstn       in   1         asynchronous reset, active low
//  issue_vld  in   1         a tree beat was launched this cycle
//  issue_last in   1         launched beat is last of its vector; qualified by issue_vld
//  sum_in     in   DATA_LEN  tree output; valid TREE_LAT cycles after issue
//  res_data   out  ACC_LEN   finished dot product
//  res_valid  out  1         res_data valid
//  res_ready  in   1         consumer accepts when res_valid & res_ready
//  busy       out  1         state RUN, or any delay-line valid bit set, or res_valid
//  ovf_err    out  1         sticky: a finished result was dropped (result reg full)
//  err_clr    in   1         clears ovf_err
// BEHAVIOUR
//  - Reset (async, rstn=0): delay line, acc, res_data, res_valid, ovf_err = 0; FSM = IDLE.
//  - Delay line: TREE_LAT-deep shift of {issue_vld, issue_last&issue_vld}; outputs v_d, l_d.
//  - sum_in sampled only when v_d=1; sign-extended to ACC_LEN; nxt = acc + sext(sum_in).
//  - FSM: IDLE -> RUN on v_d & !l_d (acc <= sext(sum_in)).
//         IDLE stays on v_d & l_d: single-beat vector completes, value = sext(sum_in).
//         RUN stays on v_d & !l_d (acc <= nxt).
//         RUN -> IDLE on v_d & l_d: completes with nxt; acc <= 0.
//         No v_d: hold state and acc; gaps inside a vector are legal.
//  - Completion loads res_data, sets res_valid the next edge.
//    Latency: issue of last beat at cycle t -> res_valid=1 at t+TREE_LAT+1.
//  - Result register: cleared by res_valid & res_ready unless a completion occurs the
//    same cycle. Completion while res_valid & !res_ready: new result dropped, old held,
//    ovf_err set. Completion with res_valid & res_ready: load new, res_valid stays 1.
//    Accumulation never stalls; tree is free-running.
//  - ovf_err: set on drop, cleared by err_clr; simultaneous set and clear -> set wins.
//  - Back-to-back vectors (last beat then first beat next cycle) need no bubble.
//  - Reset mid-vector discards partial acc and in-flight beats; no residue afterwards.
// CONFIGURATION
//  ACC_SAT_EN defined: every add (incl. completion) saturates signed: clamp to
//   2^(ACC_LEN-1)-1 on positive overflow, -2^(ACC_LEN-1) on negative.
//   Once clamped, later adds continue from the clamped value.
//  ACC_SAT_EN undefined: adds wrap modulo 2^ACC_LEN; no saturation logic synthesised.
// TESTING (TREE_LAT=2 unless stated)
//  1. 4-beat vector with sums 1,2,3,4, res_ready=1 -> res_data=10.
//     res_valid 1 cycle at t_last+3.
//  2. Single beat, issue_vld=issue_last=1, sum -5 -> res_data=40'hFF_FFFF_FFFB.
//     FSM never leaves IDLE.
//  3. Two 1-beat vectors (6, 9) back-to-back, res_ready=0 -> res_data stays 6, ovf_err=1.
//     Pulse err_clr -> ovf_err=0. Raise res_ready -> one handshake, res_valid=0.
//  4. ACC_LEN=34, 5 beats of 32'h7FFF_FFFF.
//     With ACC_SAT_EN -> 34'h1_FFFF_FFFF. Without -> 34'h2_7FFF_FFFB.
//  5. Assert rstn=0 after 2 beats of a 4-beat vector; release, then send vector 7,8
//     -> single result 15; no stale result or ovf_err.
//  6. res_valid=1 with res_ready=1 in the same cycle a new vector completes with 42
//     -> res_valid stays 1, res_data=42 next cycle, ovf_err=0.

Source files
------------

// File: rtl/dot_accumulator.sv
// dot_accumulator: accumulates the summation tree's per-beat partial sums into one
// dot-product result per vector. An internal delay line tracks tree latency, so the
// issue side drives issue_vld/issue_last together with the operands. Finished results
// wait in a single valid/ready result register. A completion that finds that register
// full and not being drained is dropped, and the drop sets ovf_err.
// Build option: define ACC_SAT_EN to make every add saturate as a signed value.
// Without ACC_SAT_EN, adds wrap modulo 2^ACC_LEN.
module dot_accumulator #(
  parameter int DATA_LEN = 32,
  parameter int ACC_LEN  = 40,
  parameter int TREE_LAT = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                issue_vld,
  input  logic                issue_last,
  input  logic [DATA_LEN-1:0] sum_in,
  output logic [ACC_LEN-1:0]  res_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                busy,
  output logic                ovf_err,
  input  logic                err_clr
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state_reg;
  state_t                    state_next;
  logic [TREE_LAT-1:0]       vld_line;
  logic [TREE_LAT-1:0]       last_line;
  logic                      v_d;
  logic                      l_d;
  logic signed [ACC_LEN-1:0] acc_reg;
  logic signed [ACC_LEN-1:0] acc_next;
  logic signed [ACC_LEN-1:0] sum_ext;
  logic signed [ACC_LEN-1:0] base;
  logic signed [ACC_LEN-1:0] nxt;
  logic                      done;
  logic                      drop;

  // Delay line: stage 0 captures the issue strobes, each later stage shifts the previous one
  genvar gi;
  generate
    for (gi = 0; gi < TREE_LAT; gi++) begin : g_line
      if (gi == 0) begin : g_head
        // First stage: the last flag only counts when the beat is actually valid
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            vld_line[gi]  <= 1'b0;
            last_line[gi] <= 1'b0;
          end else begin
            vld_line[gi]  <= issue_vld;
            last_line[gi] <= issue_vld & issue_last;
          end
        end
      end else begin : g_tail
        // Later stages: plain shift toward the tree-output end
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            vld_line[gi]  <= 1'b0;
            last_line[gi] <= 1'b0;
          end else begin
            vld_line[gi]  <= vld_line[gi-1];
            last_line[gi] <= last_line[gi-1];
          end
        end
      end
    end
  endgenerate

  assign v_d = vld_line[TREE_LAT-1];
  assign l_d = last_line[TREE_LAT-1];

  // A vector's first beat starts from zero, so the IDLE completion value is just sext(sum_in)
  assign sum_ext = ACC_LEN'(signed'(sum_in));
  assign base    = (state_reg == RUN) ? acc_reg : '0;

`ifdef ACC_SAT_EN
  logic signed [ACC_LEN:0] wide_sum;
  assign wide_sum = {base[ACC_LEN-1], base} + {sum_ext[ACC_LEN-1], sum_ext};

  // Saturating add: the two top bits of the widened sum disagree only on signed overflow
  always_comb begin
    nxt = wide_sum[ACC_LEN-1:0];
    if (wide_sum[ACC_LEN] != wide_sum[ACC_LEN-1]) begin
      nxt = wide_sum[ACC_LEN] ? {1'b1, {(ACC_LEN-1){1'b0}}} : {1'b0, {(ACC_LEN-1){1'b1}}};
    end
  end
`else
  assign nxt = base + sum_ext;
`endif

  // FSM next state and accumulator update; sum_in is ignored unless a delayed beat is valid
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    done       = 1'b0;
    if (v_d) begin
      case (state_reg)
        IDLE: begin
          if (l_d) begin
            done = 1'b1;
          end else begin
            acc_next   = nxt;
            state_next = RUN;
          end
        end
        RUN: begin
          if (l_d) begin
            done       = 1'b1;
            acc_next   = '0;
            state_next = IDLE;
          end else begin
            acc_next = nxt;
          end
        end
        default: begin
          state_next = IDLE;
          acc_next   = '0;
        end
      endcase
    end
  end

  // State and accumulator registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
    end
  end

  // Accumulation never stalls, so a completion that cannot be stored is lost
  assign drop = done & res_valid & ~res_ready;

  // Result register: a completion loads it (even during a handshake), otherwise a handshake empties it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_data  <= '0;
      res_valid <= 1'b0;
    end else if (done && !drop) begin
      res_data  <= nxt;
      res_valid <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Sticky overflow flag; a drop in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_err <= 1'b0;
    end else if (drop) begin
      ovf_err <= 1'b1;
    end else if (err_clr) begin
      ovf_err <= 1'b0;
    end
  end

  assign busy = (state_reg == RUN) | (|vld_line) | res_valid;

endmodule
